spi_sram_responder: RTL and testbench
=====================================

# spi_sram_responder

SPI-mode-0 responder that emulates a 23LC-style serial SRAM inside the FPGA. The Raspberry Pi, or any master that speaks the existing SRAM READ/WRITE framing, can use the FPGA as the target device. It holds a byte array, decodes READ/WRITE/RDSR/WRSR, and honours byte, page and sequential modes. Every committed byte write is also published on a strobe port so accelerator logic can observe host writes.

## Interface
- MEM_DEPTH, 256: bytes of storage, power of two, ≥32. Uses address bits [$clog2(MEM_DEPTH)-1:0]; upper address bits are ignored.
- SYNC_STAGES, 2: synchronizer depth on sclk/cs/mosi.
- clk  in  1  system clock; reset is asynchronous and active-high
- rst  in  1  asynchronous, active-high reset
- sclk  in  1  SPI clock from master; async to clk; must be ≤ clk/8
- cs  in  1  chip select, active low
- mosi  in  1  master-out serial data
- miso  out  1  responder-out serial data; 0 when cs high or idle
- busy  out  1  synchronized cs is asserted
- wr_strobe  out  1  one-clk pulse per committed byte write
- wr_addr  out  $clog2(MEM_DEPTH)  address of committed byte
- wr_data  out  8  committed byte

## Operation
- Opcodes: 0x03 READ, 0x02 WRITE, 0x05 RDSR, 0x01 WRSR. MSB first.
- SPI mode 0: sample mosi on synchronized sclk rising edge; update miso on falling edge.
- States:
  - IDLE: entered when cs is high. bit_cnt=0.
  - CMD: 8 bits. Then READ/WRITE→ADDR, RDSR→STAT_RD, WRSR→STAT_WR, anything else→IGNORE.
  - ADDR: 24 bits. Then READ→DATA_RD, WRITE→DATA_WR.
  - DATA_RD: on the 24th address rising edge, issue the memory read. The falling edge after it loads the byte; bit7 goes to miso. Each later falling edge shifts. After 8 bits, advance the address per mode and prefetch the next byte.
  - DATA_WR: shift in 8 bits. On the 8th rising edge, write mem[addr] on the next clk, pulse wr_strobe, then advance the address.
  - STAT_RD: shift mode register out, repeated while clocked.
  - STAT_WR: after 8 bits, mode ← byte & 0xC0.
  - IGNORE: miso=0 until cs high.
- Mode register bits [7:6]:
  - 00 byte: after the first data byte, further reads return 0x00 and further writes are discarded.
  - 10 page: only addr[4:0] increments, wrapping within a 32-byte page.
  - 01 sequential: full address increments, wrapping at MEM_DEPTH-1→0.
  - 11: treated as byte mode.
- Reset value of mode is 0x40 (sequential).
- cs rising edge in any state → IDLE on the next clk. A partial data byte is discarded with no write, and a partial WRSR leaves mode unchanged.

## Timing
- Reset values:
  - Outputs: miso=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0.
  - Internal: state=IDLE, mode=0x40.
  - Memory contents are not reset.
- Sync latency is SYNC_STAGES+1 clk from a pin edge to edge detect.
- miso is valid no later than SYNC_STAGES+3 clk after the sclk falling pin edge. This requires sclk half-period ≥4 clk.
- Memory reads are registered with 1-clk latency; a prefetch completes before the next falling edge.
- wr_strobe is high for exactly 1 clk, the same clk the memory write occurs. wr_addr/wr_data hold until the next strobe.
- Simultaneous cs rise and 8th rising edge in the same detect clk: cs wins, and the byte is discarded.
- Async rst mid-transfer: immediate IDLE; the master must reassert cs.

## Structure
- Package spi_sram_pkg:
  - opcode localparams (OP_READ, OP_WRITE, OP_RDSR, OP_WRSR);
  - mode_t enum (MODE_BYTE, MODE_PAGE, MODE_SEQ);
  - state_t enum;
  - PAGE_SIZE=32.
- Sub-module spi_sync_edge: SYNC_STAGES-deep synchronizer for sclk/cs/mosi. Outputs sclk_rise, sclk_fall, cs_n_sync, cs_rise, mosi_sync.
- Memory array is inferred in the top level as a simple dual-port RAM.

## Test plan
- Basic write/read: WRITE 0x02, addr 0x000010, data 0xA5; then READ 0x03, addr 0x000010 → miso 0xA5. wr_strobe pulses once with wr_addr=0x10, wr_data=0xA5.
- Sequential wrap: sequential WRITE at 0x0000FF of 0x11,0x22,0x33 (MEM_DEPTH=256) → mem[0xFF]=0x11, mem[0x00]=0x22, mem[0x01]=0x33. A 3-byte READ at 0xFF returns the same.
- Status register: RDSR after reset → 0x40. WRSR 0x00 then RDSR → 0x00. A 2-byte WRITE at 0x20 (0xAA,0xBB) → only mem[0x20]=0xAA, one strobe; a 2-byte READ returns 0xAA, 0x00.
- Page wrap: WRSR 0x80, then WRITE at 0x3F of 0x01,0x02 → mem[0x3F]=0x01, mem[0x20]=0x02.
- Aborted write: WRITE at 0x05, 4 data bits, then cs high → mem[0x05] unchanged and no wr_strobe. The next transaction decodes normally.
- Robustness: opcode 0x9F with 16 extra clocks → miso held 0, no strobe. Assert rst mid-READ → miso=0, state IDLE, mode=0x40.

Source files
------------

// File: rtl/spi_sram_pkg.sv
// Shared types and constants for the SPI serial-SRAM responder.
package spi_sram_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WRSR  = 8'h01;

  localparam int unsigned PAGE_SIZE = 32;

  // Encodings match mode register bits [7:6]
  typedef enum logic [1:0] {
    MODE_BYTE = 2'b00,
    MODE_SEQ  = 2'b01,
    MODE_PAGE = 2'b10
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA_RD,
    ST_DATA_WR,
    ST_STAT_RD,
    ST_STAT_WR,
    ST_IGNORE
  } state_t;

  // Bits [7:6] = 2'b11 behave like byte mode
  function automatic mode_t decode_mode(input logic [7:0] m);
    case (m[7:6])
      2'b01:   return MODE_SEQ;
      2'b10:   return MODE_PAGE;
      default: return MODE_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/spi_sram_responder_if.sv
// SPI pins plus the committed-write observation port.
interface spi_sram_responder_if #(
  parameter int unsigned MEM_DEPTH = 256
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic          sclk;
  logic          cs;
  logic          mosi;
  logic          miso;
  logic          busy;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  modport slave (
    input  sclk, cs, mosi,
    output miso, busy, wr_strobe, wr_addr, wr_data
  );

  modport master (
    output sclk, cs, mosi,
    input  miso, busy, wr_strobe, wr_addr, wr_data
  );

endinterface

// File: rtl/spi_sram_responder_sync_edge.sv
// Synchronizes sclk/cs/mosi into clk and produces registered edge pulses.
// All outputs share one output register stage so they stay aligned.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_sync,
  output logic cs_rise,
  output logic mosi_sync
);

  logic [SYNC_STAGES-1:0] sclk_sr;
  logic [SYNC_STAGES-1:0] cs_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   sclk_prev;

  // Synchronizer chains, then edge detection against the previous sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sr   <= '0;
      cs_sr     <= '1;
      mosi_sr   <= '0;
      sclk_prev <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_n_sync <= 1'b1;
      cs_rise   <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sclk_sr[0] <= sclk;
      cs_sr[0]   <= cs;
      mosi_sr[0] <= mosi;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sclk_sr[i] <= sclk_sr[i-1];
        cs_sr[i]   <= cs_sr[i-1];
        mosi_sr[i] <= mosi_sr[i-1];
      end
      sclk_prev <= sclk_sr[SYNC_STAGES-1];
      sclk_rise <= sclk_sr[SYNC_STAGES-1] & ~sclk_prev;
      sclk_fall <= ~sclk_sr[SYNC_STAGES-1] & sclk_prev;
      cs_n_sync <= cs_sr[SYNC_STAGES-1];
      cs_rise   <= cs_sr[SYNC_STAGES-1] & ~cs_n_sync;
      mosi_sync <= mosi_sr[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 responder emulating a 23LC-style serial SRAM.
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  spi_sram_responder_if.slave bus
);

  localparam int unsigned      AW        = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0]    PAGE_MASK = AW'(PAGE_SIZE - 1);

  logic sclk_rise, sclk_fall, cs_n_sync, cs_rise, mosi_sync;

  state_t        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d, op_q, op_d, mode_q, mode_d, tx_q, tx_d;
  logic [AW-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d, addr_inc;
  logic [7:0]    wr_data_q, wr_data_d, rdata_q, rx_byte, ld_byte;
  logic          miso_q, miso_d, first_q, first_d, wr_stb_q, wr_stb_d;
  logic          byte_mode;
  mode_t         mode_dec;

  logic [7:0] mem [MEM_DEPTH];

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (bus.sclk),
    .cs        (bus.cs),
    .mosi      (bus.mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_n_sync (cs_n_sync),
    .cs_rise   (cs_rise),
    .mosi_sync (mosi_sync)
  );

  // Address advance, incoming byte and outgoing byte selection
  always_comb begin
    mode_dec  = decode_mode(mode_q);
    byte_mode = (mode_dec == MODE_BYTE);
    rx_byte   = {sh_q[6:0], mosi_sync};
    case (mode_dec)
      MODE_SEQ:  addr_inc = addr_q + AW'(1);
      MODE_PAGE: addr_inc = (addr_q & ~PAGE_MASK) | ((addr_q + AW'(1)) & PAGE_MASK);
      default:   addr_inc = addr_q;
    endcase
    if (state_q == ST_STAT_RD)      ld_byte = mode_q;
    else if (byte_mode && first_q)  ld_byte = '0;
    else                            ld_byte = rdata_q;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      op_q      <= '0;
      mode_q    <= 8'h40;
      tx_q      <= '0;
      addr_q    <= '0;
      miso_q    <= 1'b0;
      first_q   <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      op_q      <= op_d;
      mode_q    <= mode_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      miso_q    <= miso_d;
      first_q   <= first_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state and datapath updates; deasserted cs overrides everything,
  // so a byte completing in the same clk as cs rising is dropped
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    op_d      = op_q;
    mode_d    = mode_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    miso_d    = miso_q;
    first_d   = first_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (cs_n_sync || cs_rise) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
      first_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end
        ST_CMD: if (sclk_rise) begin
          sh_d  = rx_byte;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d = '0;
            op_d  = rx_byte;
            case (rx_byte)
              OP_READ, OP_WRITE: state_d = ST_ADDR;
              OP_RDSR:           state_d = ST_STAT_RD;
              OP_WRSR:           state_d = ST_STAT_WR;
              default:           state_d = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: if (sclk_rise) begin
          // Shifting into an AW-bit register drops the unused upper bits
          addr_d = {addr_q[AW-2:0], mosi_sync};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            cnt_d   = '0;
            state_d = (op_q == OP_READ) ? ST_DATA_RD : ST_DATA_WR;
          end
        end
        ST_DATA_RD, ST_STAT_RD: if (sclk_fall) begin
          cnt_d = (cnt_q == 5'd7) ? 5'd0 : cnt_q + 5'd1;
          if (cnt_q == 5'd0) begin
            // Advancing on load gives the RAM a full byte time to prefetch
            tx_d   = ld_byte;
            miso_d = ld_byte[7];
            if (state_q == ST_DATA_RD) begin
              first_d = 1'b1;
              addr_d  = addr_inc;
            end
          end else begin
            tx_d   = {tx_q[6:0], 1'b0};
            miso_d = tx_q[6];
          end
        end
        ST_DATA_WR: if (sclk_rise) begin
          sh_d  = rx_byte;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d = '0;
            if (!(byte_mode && first_q)) begin
              wr_stb_d  = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = rx_byte;
              addr_d    = addr_inc;
              first_d   = 1'b1;
            end
          end
        end
        ST_STAT_WR: if (sclk_rise) begin
          sh_d  = rx_byte;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d   = '0;
            mode_d  = rx_byte & 8'hC0;
            state_d = ST_IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  // Simple dual-port RAM: write during the strobe clk, registered read
  always_ff @(posedge clk) begin
    if (wr_stb_q) mem[wr_addr_q] <= wr_data_q;
    rdata_q <= mem[addr_q];
  end

  assign bus.miso      = miso_q;
  assign bus.busy      = ~cs_n_sync;
  assign bus.wr_strobe = wr_stb_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Scoreboard bench for spi_sram_responder acting as an SPI mode-0 master.
module tb_spi_sram_responder;

  localparam int unsigned MEM_DEPTH = 256;
  localparam int          HALF      = 8;
  localparam logic [7:0]  C_READ    = 8'h03;
  localparam logic [7:0]  C_WRITE   = 8'h02;
  localparam logic [7:0]  C_RDSR    = 8'h05;
  localparam logic [7:0]  C_WRSR    = 8'h01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_sram_responder_if #(.MEM_DEPTH(MEM_DEPTH)) sif ();

  spi_sram_responder #(.MEM_DEPTH(MEM_DEPTH), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] strobe_q[$];
  logic [7:0]  model [256];
  logic [7:0]  model_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every strobe clk must match the oldest expected committed write
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && sif.wr_strobe === 1'b1) begin
      e = (strobe_q.size() > 0) ? strobe_q.pop_front() : 16'hxxxx;
      check("wr_strobe", {sif.wr_addr, sif.wr_data}, e);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic byte_mode_m();
    return !(model_mode[7:6] == 2'b01 || model_mode[7:6] == 2'b10);
  endfunction

  function automatic logic [7:0] adv(input logic [7:0] p);
    case (model_mode[7:6])
      2'b01:   return p + 8'd1;
      2'b10:   return {p[7:5], p[4:0] + 5'd1};
      default: return p;
    endcase
  endfunction

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      sif.mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = sif.miso;
      sif.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sif.sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    sif.cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    sif.cs   = 1'b1;
    sif.mosi = 1'b0;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] rx;
    xfer(op, 8, rx);
    xfer(a[23:16], 8, rx);
    xfer(a[15:8], 8, rx);
    xfer(a[7:0], 8, rx);
  endtask

  task automatic sram_write(input logic [23:0] a, input int n,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] d [3];
    logic [7:0] p, rx;
    d[0] = d0; d[1] = d1; d[2] = d2;
    p = a[7:0];
    for (int k = 0; k < n; k++) begin
      if (k == 0 || !byte_mode_m()) begin
        model[p] = d[k];
        strobe_q.push_back({p, d[k]});
        p = adv(p);
      end
    end
    cs_begin();
    send_hdr(C_WRITE, a);
    for (int k = 0; k < n; k++) xfer(d[k], 8, rx);
    cs_end();
  endtask

  task automatic sram_read(input logic [23:0] a, input int n, input string tag);
    logic [7:0] p, rx;
    p = a[7:0];
    for (int k = 0; k < n; k++) begin
      exp_q.push_back((k > 0 && byte_mode_m()) ? 8'h00 : model[p]);
      p = adv(p);
    end
    cs_begin();
    send_hdr(C_READ, a);
    for (int k = 0; k < n; k++) begin
      xfer(8'h00, 8, rx);
      check($sformatf("%s[%0d]", tag, k), rx, exp_q.pop_front());
    end
    cs_end();
  endtask

  task automatic rdsr(input string tag);
    logic [7:0] rx;
    exp_q.push_back(model_mode);
    cs_begin();
    xfer(C_RDSR, 8, rx);
    xfer(8'h00, 8, rx);
    check(tag, rx, exp_q.pop_front());
    cs_end();
  endtask

  task automatic wrsr(input logic [7:0] v);
    logic [7:0] rx;
    cs_begin();
    xfer(C_WRSR, 8, rx);
    xfer(v, 8, rx);
    cs_end();
    model_mode = v & 8'hC0;
  endtask

  initial begin
    logic [7:0] rx;
    sif.sclk   = 1'b0;
    sif.cs     = 1'b1;
    sif.mosi   = 1'b0;
    model_mode = 8'h40;
    repeat (4) @(negedge clk);
    check("rst_miso", sif.miso, 0);
    check("rst_busy", sif.busy, 0);
    check("rst_wr_strobe", sif.wr_strobe, 0);
    check("rst_wr_addr", sif.wr_addr, 0);
    check("rst_wr_data", sif.wr_data, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    rdsr("rdsr_reset");

    sram_write(24'h000010, 1, 8'hA5, 8'h00, 8'h00);
    sram_read(24'h000010, 1, "basic_rd");

    sram_write(24'h0000FF, 3, 8'h11, 8'h22, 8'h33);
    sram_read(24'h0000FF, 3, "seq_wrap_rd");

    wrsr(8'h00);
    rdsr("rdsr_byte");
    sram_write(24'h000020, 2, 8'hAA, 8'hBB, 8'h00);
    sram_read(24'h000020, 2, "byte_rd");

    wrsr(8'h80);
    sram_write(24'h00003F, 2, 8'h01, 8'h02, 8'h00);
    sram_read(24'h00003F, 2, "page_rd");
    sram_read(24'h000020, 1, "page_wrap_rd");

    wrsr(8'h7F);
    rdsr("rdsr_masked");

    // Partial data byte then cs high: no write, no strobe
    sram_write(24'h000005, 1, 8'h5C, 8'h00, 8'h00);
    cs_begin();
    check("busy_cs_low", sif.busy, 1);
    send_hdr(C_WRITE, 24'h000005);
    xfer(8'hF0, 4, rx);
    cs_end();
    sram_read(24'h000005, 1, "abort_rd");

    // Unknown opcode: responder stays silent
    cs_begin();
    xfer(8'h9F, 8, rx);
    xfer(8'($urandom), 8, rx);
    check("ignore_b0", rx, 0);
    xfer(8'($urandom), 8, rx);
    check("ignore_b1", rx, 0);
    cs_end();

    // Async reset in the middle of a read
    wrsr(8'h80);
    cs_begin();
    send_hdr(C_READ, 24'h000010);
    xfer(8'h00, 3, rx);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_miso", sif.miso, 0);
    check("rst_mid_busy", sif.busy, 0);
    check("rst_mid_wr_addr", sif.wr_addr, 0);
    repeat (2) @(negedge clk);
    sif.cs = 1'b1;
    rst    = 1'b0;
    model_mode = 8'h40;
    repeat (2 * HALF) @(negedge clk);
    rdsr("rdsr_after_rst");
    sram_read(24'h000010, 1, "rd_after_rst");

    repeat (4) @(negedge clk);
    check("strobes_pending", strobe_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
